// File: rtl/wash_plant_sensor.sv
// Plant/responder model for the washing-machine controller: water level, wash/spin timers,
// fill watchdog and a sticky fault monitor, all driven by the controller's actuator commands.
module wash_plant_sensor #(
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned FULL_LEVEL  = 200,
    parameter int unsigned FILL_RATE   = 4,
    parameter int unsigned DRAIN_RATE  = 8,
    parameter int unsigned TIMER_W     = 16,
    parameter int unsigned CYCLE_TICKS = 1000,
    parameter int unsigned SPIN_TICKS  = 500,
    parameter int unsigned WDOG_TICKS  = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_lock,
    input  logic               fill_valve_on,
    input  logic               drain_valve_on,
    input  logic               motor_on,
    output logic               filled,
    output logic               drained,
    output logic               cycle_timeout,
    output logic               spin_timeout,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         phase,
    output logic               fault
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFilling  = 3'd1,
        StWashing  = 3'd2,
        StDraining = 3'd3,
        StSpinning = 3'd4,
        StFault    = 3'd7
    } phase_e;

    // Level arithmetic is one bit wider so the clamps see the true sum/difference.
    localparam logic [LEVEL_W:0]   FullExt   = (LEVEL_W + 1)'(FULL_LEVEL);
    localparam logic [LEVEL_W:0]   FillExt   = (LEVEL_W + 1)'(FILL_RATE);
    localparam logic [LEVEL_W:0]   DrainExt  = (LEVEL_W + 1)'(DRAIN_RATE);
    localparam logic [TIMER_W-1:0] CycleMax  = TIMER_W'(CYCLE_TICKS);
    localparam logic [TIMER_W-1:0] SpinMax   = TIMER_W'(SPIN_TICKS);
    localparam logic [TIMER_W-1:0] WdogLast  = TIMER_W'(WDOG_TICKS - 1);
    localparam logic [TIMER_W-1:0] TimerOne  = TIMER_W'(1);

    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TIMER_W-1:0] cycle_q, cycle_d;
    logic [TIMER_W-1:0] spin_q, spin_d;
    logic [TIMER_W-1:0] wdog_q, wdog_d;
    logic               fault_q;
    phase_e             phase_q, phase_d;

    logic [LEVEL_W:0]   level_ext;
    logic [LEVEL_W:0]   fill_sum;
    logic [LEVEL_W:0]   fill_next;
    logic [LEVEL_W:0]   drain_next;
    logic               at_full;
    logic               at_empty;
    logic               below_full;
    logic               valve_clash;
    logic               door_violation;
    logic               wdog_hit;
    logic               fault_cond;

    always_comb begin
        level_ext  = {1'b0, level_q};
        fill_sum   = level_ext + FillExt;
        fill_next  = (fill_sum > FullExt) ? FullExt : fill_sum;
        drain_next = (level_ext > DrainExt) ? (level_ext - DrainExt) : '0;
        at_full    = (level_ext == FullExt);
        at_empty   = (level_q == '0);
        below_full = (level_ext < FullExt);
    end

    always_comb begin
        valve_clash    = fill_valve_on && drain_valve_on;
        door_violation = !door_lock && (fill_valve_on || drain_valve_on || motor_on);
        // Expiry is flagged on the clock that would make the count reach WDOG_TICKS.
        wdog_hit       = fill_valve_on && below_full && (wdog_q == WdogLast);
        fault_cond     = valve_clash || door_violation || wdog_hit;
    end

    always_comb begin
        level_d = level_q;
        case ({fill_valve_on, drain_valve_on})
            2'b10:   level_d = fill_next[LEVEL_W-1:0];
            2'b01:   level_d = drain_next[LEVEL_W-1:0];
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        cycle_d = '0;
        if (motor_on) begin
            cycle_d = (cycle_q == CycleMax) ? cycle_q : cycle_q + TimerOne;
        end

        spin_d = '0;
        if (drain_valve_on && at_empty) begin
            spin_d = (spin_q == SpinMax) ? spin_q : spin_q + TimerOne;
        end

        wdog_d = '0;
        if (fill_valve_on && below_full) begin
            wdog_d = wdog_q + TimerOne;
        end
    end

    always_comb begin
        phase_d = StIdle;
        if (fill_valve_on) begin
            phase_d = StFilling;
        end else if (motor_on) begin
            phase_d = StWashing;
        end else if (drain_valve_on) begin
            phase_d = at_empty ? StSpinning : StDraining;
        end
    end

    // Once faulted, everything freezes until reset; a new fault also suppresses that clock's update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            cycle_q <= '0;
            spin_q  <= '0;
            wdog_q  <= '0;
            fault_q <= 1'b0;
            phase_q <= StIdle;
        end else if (!fault_q) begin
            if (fault_cond) begin
                fault_q <= 1'b1;
                phase_q <= StFault;
            end else begin
                level_q <= level_d;
                cycle_q <= cycle_d;
                spin_q  <= spin_d;
                wdog_q  <= wdog_d;
                phase_q <= phase_d;
            end
        end
    end

    always_comb begin
        level         = level_q;
        phase         = phase_q;
        fault         = fault_q;
        filled        = at_full && !fault_q;
        drained       = at_empty && !fault_q;
        cycle_timeout = (cycle_q == CycleMax) && !fault_q;
        spin_timeout  = (spin_q == SpinMax) && !fault_q;
    end

endmodule

// File: tb/tb_wash_plant_sensor.sv
// Self-checking bench for wash_plant_sensor: directed plan steps plus randomized command
// sequences compared against an integer-arithmetic plant model.
module tb_wash_plant_sensor;

    localparam int FULL  = 200;
    localparam int FRATE = 4;
    localparam int DRATE = 8;
    localparam int CYC   = 1000;
    localparam int SPIN  = 500;
    localparam int WDOG  = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       door_lock = 1'b0;
    logic       fill_valve_on = 1'b0;
    logic       drain_valve_on = 1'b0;
    logic       motor_on = 1'b0;
    logic       filled, drained, cycle_timeout, spin_timeout, fault;
    logic [7:0] level;
    logic [2:0] phase;

    logic       wd_fill = 1'b0;
    logic       wd_filled, wd_drained, wd_cto, wd_sto, wd_fault;
    logic [7:0] wd_level;
    logic [2:0] wd_phase;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int m_level, m_cycle, m_spin, m_wdog, m_phase;
    bit m_fault;

    always #5 clk = ~clk;

    wash_plant_sensor dut (
        .clk           (clk),
        .reset         (reset),
        .door_lock     (door_lock),
        .fill_valve_on (fill_valve_on),
        .drain_valve_on(drain_valve_on),
        .motor_on      (motor_on),
        .filled        (filled),
        .drained       (drained),
        .cycle_timeout (cycle_timeout),
        .spin_timeout  (spin_timeout),
        .level         (level),
        .phase         (phase),
        .fault         (fault)
    );

    wash_plant_sensor #(
        .FULL_LEVEL(255),
        .FILL_RATE (0)
    ) dut_wd (
        .clk           (clk),
        .reset         (reset),
        .door_lock     (1'b1),
        .fill_valve_on (wd_fill),
        .drain_valve_on(1'b0),
        .motor_on      (1'b0),
        .filled        (wd_filled),
        .drained       (wd_drained),
        .cycle_timeout (wd_cto),
        .spin_timeout  (wd_sto),
        .level         (wd_level),
        .phase         (wd_phase),
        .fault         (wd_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_cycle = 0; m_spin = 0; m_wdog = 0; m_phase = 0; m_fault = 1'b0;
    endtask

    // One rising edge of the plant, computed from the rules on the inputs present at that edge.
    task automatic model_edge();
        bit cond;
        int old_level;
        if (m_fault) return;
        cond = (fill_valve_on && drain_valve_on)
            || (!door_lock && (fill_valve_on || drain_valve_on || motor_on))
            || (fill_valve_on && m_level < FULL && m_wdog + 1 >= WDOG);
        if (cond) begin
            m_fault = 1'b1;
            m_phase = 7;
            return;
        end
        old_level = m_level;
        if (fill_valve_on)       m_phase = 1;
        else if (motor_on)       m_phase = 2;
        else if (drain_valve_on) m_phase = (old_level > 0) ? 3 : 4;
        else                     m_phase = 0;
        m_cycle = motor_on ? ((m_cycle + 1 > CYC) ? CYC : m_cycle + 1) : 0;
        m_spin  = (drain_valve_on && old_level == 0) ? ((m_spin + 1 > SPIN) ? SPIN : m_spin + 1) : 0;
        m_wdog  = (fill_valve_on && old_level < FULL) ? m_wdog + 1 : 0;
        if (fill_valve_on && !drain_valve_on)
            m_level = (old_level + FRATE > FULL) ? FULL : old_level + FRATE;
        else if (drain_valve_on && !fill_valve_on)
            m_level = (old_level - DRATE < 0) ? 0 : old_level - DRATE;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(m_level));
        chk({tag, ".filled"}, 32'(filled), 32'(!m_fault && m_level == FULL));
        chk({tag, ".drained"}, 32'(drained), 32'(!m_fault && m_level == 0));
        chk({tag, ".cycle_timeout"}, 32'(cycle_timeout), 32'(!m_fault && m_cycle == CYC));
        chk({tag, ".spin_timeout"}, 32'(spin_timeout), 32'(!m_fault && m_spin == SPIN));
        chk({tag, ".phase"}, 32'(phase), 32'(m_phase));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Called away from the clock edge; checks the asynchronous clear before any edge arrives.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        fill_valve_on = 1'b0; drain_valve_on = 1'b0; motor_on = 1'b0; door_lock = 1'b1;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        reset = 1'b1;
        door_lock = 1'b1;

        // Fill to full and hold at the clamp
        fill_valve_on = 1'b1;
        steps(49, "fill");
        step("fill50");
        chk("fill50_level", 32'(level), 32'd200);
        chk("fill50_filled", 32'(filled), 32'd1);
        steps(10, "fill_hold");
        chk("fill_phase", 32'(phase), 32'd1);

        // Wash timer
        fill_valve_on = 1'b0;
        motor_on = 1'b1;
        steps(999, "wash");
        chk("wash999_cto", 32'(cycle_timeout), 32'd0);
        step("wash1000");
        chk("wash1000_cto", 32'(cycle_timeout), 32'd1);
        chk("wash_phase", 32'(phase), 32'd2);
        steps(3, "wash_hold");
        motor_on = 1'b0;
        step("wash_drop");
        chk("wash_drop_cto", 32'(cycle_timeout), 32'd0);

        // Drain, then spin timer
        drain_valve_on = 1'b1;
        step("drain1");
        chk("drain_phase", 32'(phase), 32'd3);
        steps(24, "drain");
        chk("drain25_drained", 32'(drained), 32'd1);
        steps(499, "spin");
        chk("spin499_sto", 32'(spin_timeout), 32'd0);
        chk("spin_phase", 32'(phase), 32'd4);
        step("spin500");
        chk("spin500_sto", 32'(spin_timeout), 32'd1);
        drain_valve_on = 1'b0;
        step("spin_drop");

        // Valve clash at level 100
        do_reset("rst_clash");
        fill_valve_on = 1'b1;
        steps(25, "clash_fill");
        chk("clash_level", 32'(level), 32'd100);
        drain_valve_on = 1'b1;
        step("clash");
        chk("clash_fault", 32'(fault), 32'd1);
        chk("clash_phase", 32'(phase), 32'd7);
        fill_valve_on = 1'b0;
        steps(5, "clash_frozen");
        chk("clash_frozen_level", 32'(level), 32'd100);

        // Motor with door open
        do_reset("rst_door");
        door_lock = 1'b0;
        motor_on = 1'b1;
        step("door");
        chk("door_fault", 32'(fault), 32'd1);
        door_lock = 1'b1;
        motor_on = 1'b0;
        step("door_sticky");

        // Asynchronous reset mid-fill
        do_reset("rst_midfill_pre");
        fill_valve_on = 1'b1;
        steps(30, "midfill");
        chk("midfill_level", 32'(level), 32'd120);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_level", 32'(level), 32'd0);
        chk("async_drained", 32'(drained), 32'd1);
        chk("async_fault", 32'(fault), 32'd0);
        chk("async_phase", 32'(phase), 32'd0);
        fill_valve_on = 1'b0;
        #1;
        reset = 1'b1;

        // Randomized command sequences
        for (int seg = 0; seg < 120; seg++) begin
            int mode, len;
            if (m_fault || $urandom_range(0, 15) == 0) do_reset("rand_rst");
            mode = $urandom_range(0, 9);
            len  = $urandom_range(1, 40);
            door_lock      = ($urandom_range(0, 19) != 0);
            fill_valve_on  = (mode <= 2);
            drain_valve_on = (mode >= 3 && mode <= 5);
            motor_on       = (mode == 6 || mode == 7);
            if (mode == 9) begin
                fill_valve_on  = 1'($urandom_range(0, 1));
                drain_valve_on = 1'($urandom_range(0, 1));
                motor_on       = 1'($urandom_range(0, 1));
            end
            steps(len, "rand");
        end

        // Watchdog on an instance whose full level is unreachable
        do_reset("rst_wd");
        chk("wd_reset_fault", 32'(wd_fault), 32'd0);
        wd_fill = 1'b1;
        repeat (4095) @(posedge clk);
        #1;
        chk("wd4095_fault", 32'(wd_fault), 32'd0);
        chk("wd4095_phase", 32'(wd_phase), 32'd1);
        @(posedge clk);
        #1;
        chk("wd4096_fault", 32'(wd_fault), 32'd1);
        chk("wd4096_phase", 32'(wd_phase), 32'd7);
        chk("wd4096_drained", 32'(wd_drained), 32'd0);
        wd_fill = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
